// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver: 1 start, 7 data bits LSB-first, even parity, 1 stop.
// Mid-bit sampling off a two-flop synchronized RX; one-cycle pronto per completed frame.
module rx_serial_7e1 #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    output logic [6:0] dado_recebido,
    output logic       pronto,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic       ocupado
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        INICIAL,
        START,
        DADOS,
        PARIDADE,
        STOP,
        FIM,
        ESPERA
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [CW-1:0]   tick_cnt;
    logic [2:0]      bit_cnt;
    logic [6:0]      sr;
    logic            par_err;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM; outputs are loaded on the edge into FIM so they are valid during FIM.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= INICIAL;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            sr            <= '0;
            par_err       <= 1'b0;
            dado_recebido <= '0;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_stop     <= 1'b0;
            ocupado       <= 1'b0;
        end else begin
            pronto   <= 1'b0;
            tick_cnt <= tick_cnt + CW'(1);
            case (state)
                INICIAL: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rx_s) begin
                        state   <= START;
                        ocupado <= 1'b1;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_cnt <= '0;
                        if (rx_s) begin
                            state   <= INICIAL;
                            ocupado <= 1'b0;
                        end else begin
                            state <= DADOS;
                        end
                    end
                end
                DADOS: begin
                    if (tick_cnt == BAUD_LAST) begin
                        tick_cnt <= '0;
                        sr       <= {rx_s, sr[6:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd6) begin
                            state <= PARIDADE;
                        end
                    end
                end
                PARIDADE: begin
                    if (tick_cnt == BAUD_LAST) begin
                        tick_cnt <= '0;
                        par_err  <= rx_s ^ (^sr);
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (tick_cnt == BAUD_LAST) begin
                        tick_cnt      <= '0;
                        dado_recebido <= sr;
                        erro_paridade <= par_err;
                        erro_stop     <= ~rx_s;
                        pronto        <= 1'b1;
                        state         <= FIM;
                    end
                end
                FIM: begin
                    tick_cnt <= '0;
                    if (!erro_stop) begin
                        state   <= INICIAL;
                        ocupado <= 1'b0;
                    end else begin
                        state <= ESPERA;
                    end
                end
                ESPERA: begin
                    // A held-low line (break) must go idle before a new start is accepted.
                    tick_cnt <= '0;
                    if (rx_s) begin
                        state   <= INICIAL;
                        ocupado <= 1'b0;
                    end
                end
                default: begin
                    tick_cnt <= '0;
                    state    <= INICIAL;
                    ocupado  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Self-checking bench for rx_serial_7e1: frames built from the 7E1 rules, decoded
// results and latency compared against a record-level reference model.
module tb_rx_serial_7e1;

    localparam int B   = 16;
    localparam int H   = 8;
    localparam int LAT = H + 9 * B + 1;

    typedef struct {
        logic [6:0] data;
        logic       perr;
        logic       serr;
        int         lat;
    } rec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       RX = 1'b1;
    logic [6:0] dado_recebido;
    logic       pronto;
    logic       erro_paridade;
    logic       erro_stop;
    logic       ocupado;

    int   cyc = 0;
    int   last_fall = 0;
    int   multi = 0;
    logic pronto_prev = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    rec_t got_q[$];
    rec_t exp_q[$];
    logic [6:0] m_data = '0;
    logic       m_perr = 1'b0;
    logic       m_serr = 1'b0;

    rx_serial_7e1 #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
        .clock(clock),
        .reset(reset),
        .RX(RX),
        .dado_recebido(dado_recebido),
        .pronto(pronto),
        .erro_paridade(erro_paridade),
        .erro_stop(erro_stop),
        .ocupado(ocupado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Record every pronto pulse; the start edge is driven 2 cycles before t0.
    always @(negedge clock) begin
        if (pronto) begin
            got_q.push_back('{data: dado_recebido, perr: erro_paridade, serr: erro_stop,
                              lat: cyc - last_fall - 2});
            if (pronto_prev) multi = multi + 1;
        end
        pronto_prev = pronto;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle(input int nbits);
        RX = 1'b1;
        repeat (nbits * B) @(negedge clock);
    endtask

    task automatic send_frame(input logic [6:0] d, input logic pbit, input logic sbit);
        logic [9:0] bits;
        bits = {sbit, pbit, d, 1'b0};
        last_fall = cyc;
        m_data = d;
        m_perr = pbit ^ (^d);
        m_serr = ~sbit;
        exp_q.push_back('{data: d, perr: m_perr, serr: m_serr, lat: LAT});
        for (int i = 0; i < 10; i++) begin
            RX = bits[i];
            repeat (B) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        RX = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n_checks += 5;
        if (dado_recebido !== 7'h00) $display("FAIL reset_data: got %h expected 00", dado_recebido); else n_pass++;
        if (pronto !== 1'b0) $display("FAIL reset_pronto: got %b expected 0", pronto); else n_pass++;
        if (erro_paridade !== 1'b0) $display("FAIL reset_perr: got %b expected 0", erro_paridade); else n_pass++;
        if (erro_stop !== 1'b0) $display("FAIL reset_serr: got %b expected 0", erro_stop); else n_pass++;
        if (ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b expected 0", ocupado); else n_pass++;
    endtask

    task automatic test_good_frames();
        rec_t e, g;
        idle(10);
        send_frame(7'h2A, ^7'h2A, 1'b1);
        idle(10);
        send_frame(7'h4C, ^7'h4C, 1'b1);
        idle(10);
        send_frame(7'h70, ^7'h70, 1'b1);
        idle(2);
        n_checks++;
        if (got_q.size() != 3) $display("FAIL good_count: got %0d expected 3", got_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks += 4;
            if (g.data !== e.data) $display("FAIL good_data: got %h expected %h", g.data, e.data); else n_pass++;
            if (g.perr !== e.perr) $display("FAIL good_perr: got %b expected %b", g.perr, e.perr); else n_pass++;
            if (g.serr !== e.serr) $display("FAIL good_serr: got %b expected %b", g.serr, e.serr); else n_pass++;
            if (g.lat != e.lat) $display("FAIL good_latency: got %0d expected %0d", g.lat, e.lat); else n_pass++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random_frames();
        rec_t e, g;
        logic [6:0] d;
        logic inj;
        int n;
        n = 24;
        for (int i = 0; i < n; i++) begin
            d = 7'($urandom);
            inj = ($urandom_range(0, 3) == 0);
            send_frame(d, (^d) ^ inj, 1'b1);
            idle($urandom_range(0, 3));
        end
        idle(1);
        n_checks++;
        if (got_q.size() != n) $display("FAIL random_count: got %0d expected %0d", got_q.size(), n); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks += 4;
            if (g.data !== e.data) $display("FAIL random_data: got %h expected %h", g.data, e.data); else n_pass++;
            if (g.perr !== e.perr) $display("FAIL random_perr: got %b expected %b", g.perr, e.perr); else n_pass++;
            if (g.serr !== e.serr) $display("FAIL random_serr: got %b expected %b", g.serr, e.serr); else n_pass++;
            if (g.lat != e.lat) $display("FAIL random_latency: got %0d expected %0d", g.lat, e.lat); else n_pass++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_parity_error();
        rec_t e, g;
        send_frame(7'h2A, ~(^7'h2A), 1'b1);
        idle(2);
        send_frame(7'h4C, ^7'h4C, 1'b1);
        idle(2);
        n_checks++;
        if (got_q.size() != 2) $display("FAIL parity_count: got %0d expected 2", got_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks += 3;
            if (g.data !== e.data) $display("FAIL parity_data: got %h expected %h", g.data, e.data); else n_pass++;
            if (g.perr !== e.perr) $display("FAIL parity_perr: got %b expected %b", g.perr, e.perr); else n_pass++;
            if (g.serr !== e.serr) $display("FAIL parity_serr: got %b expected %b", g.serr, e.serr); else n_pass++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_framing_break();
        rec_t e, g;
        int busy_bad;
        send_frame(7'h70, ^7'h70, 1'b0);
        busy_bad = 0;
        for (int i = 0; i < 20; i++) begin
            RX = 1'b0;
            repeat (B) @(negedge clock);
            if (ocupado !== 1'b1) busy_bad++;
        end
        n_checks += 2;
        if (busy_bad != 0) $display("FAIL break_ocupado: low in %0d of 20 samples, required 0", busy_bad); else n_pass++;
        if (got_q.size() != 1) $display("FAIL break_pronto_count: got %0d expected 1", got_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks += 3;
            if (g.data !== e.data) $display("FAIL break_data: got %h expected %h", g.data, e.data); else n_pass++;
            if (g.perr !== e.perr) $display("FAIL break_perr: got %b expected %b", g.perr, e.perr); else n_pass++;
            if (g.serr !== e.serr) $display("FAIL break_serr: got %b expected %b", g.serr, e.serr); else n_pass++;
        end
        exp_q.delete();
        got_q.delete();
        RX = 1'b1;
        repeat (5) @(negedge clock);
        n_checks++;
        if (ocupado !== 1'b0) $display("FAIL break_release_ocupado: got %b expected 0", ocupado); else n_pass++;
        idle(1);
        send_frame(7'h2A, ^7'h2A, 1'b1);
        idle(1);
        n_checks++;
        if (got_q.size() != 1) $display("FAIL after_break_count: got %0d expected 1", got_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks += 3;
            if (g.data !== e.data) $display("FAIL after_break_data: got %h expected %h", g.data, e.data); else n_pass++;
            if (g.perr !== e.perr) $display("FAIL after_break_perr: got %b expected %b", g.perr, e.perr); else n_pass++;
            if (g.serr !== e.serr) $display("FAIL after_break_serr: got %b expected %b", g.serr, e.serr); else n_pass++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_glitch();
        int len;
        int fall;
        for (int i = 0; i < 3; i++) begin
            len = $urandom_range(1, H - 2);
            fall = cyc;
            RX = 1'b0;
            repeat (len) @(negedge clock);
            RX = 1'b1;
            repeat (H + 2 - len) @(negedge clock);
            n_checks++;
            if (ocupado !== 1'b1 || cyc != fall + H + 2)
                $display("FAIL glitch_busy: got %b at +%0d expected 1 at +%0d", ocupado, cyc - fall, H + 2);
            else n_pass++;
            @(negedge clock);
            n_checks++;
            if (ocupado !== 1'b0) $display("FAIL glitch_idle: got %b expected 0", ocupado); else n_pass++;
            idle(2);
        end
        n_checks += 4;
        if (got_q.size() != 0) $display("FAIL glitch_pronto: got %0d pulses expected 0", got_q.size()); else n_pass++;
        if (dado_recebido !== m_data) $display("FAIL glitch_data: got %h expected %h", dado_recebido, m_data); else n_pass++;
        if (erro_paridade !== m_perr) $display("FAIL glitch_perr: got %b expected %b", erro_paridade, m_perr); else n_pass++;
        if (erro_stop !== m_serr) $display("FAIL glitch_serr: got %b expected %b", erro_stop, m_serr); else n_pass++;
        got_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        rec_t e, g;
        logic [9:0] bits;
        bits = {1'b1, ^7'h4C, 7'h4C, 1'b0};
        for (int i = 0; i < 4; i++) begin
            RX = bits[i];
            repeat (B) @(negedge clock);
        end
        RX = bits[4];
        repeat (B / 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        RX = 1'b1;
        m_data = '0;
        m_perr = 1'b0;
        m_serr = 1'b0;
        n_checks += 4;
        if (dado_recebido !== 7'h00) $display("FAIL midreset_data: got %h expected 00", dado_recebido); else n_pass++;
        if (erro_paridade !== 1'b0) $display("FAIL midreset_perr: got %b expected 0", erro_paridade); else n_pass++;
        if (erro_stop !== 1'b0) $display("FAIL midreset_serr: got %b expected 0", erro_stop); else n_pass++;
        if (ocupado !== 1'b0) $display("FAIL midreset_ocupado: got %b expected 0", ocupado); else n_pass++;
        idle(12);
        n_checks++;
        if (got_q.size() != 0) $display("FAIL midreset_pronto: got %0d pulses expected 0", got_q.size()); else n_pass++;
        got_q.delete();
        send_frame(7'h4C, ^7'h4C, 1'b1);
        idle(1);
        n_checks++;
        if (got_q.size() != 1) $display("FAIL midreset_next_count: got %0d expected 1", got_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks += 2;
            if (g.data !== e.data) $display("FAIL midreset_next_data: got %h expected %h", g.data, e.data); else n_pass++;
            if (g.perr !== e.perr) $display("FAIL midreset_next_perr: got %b expected %b", g.perr, e.perr); else n_pass++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_latency();
        rec_t g;
        send_frame(7'h55, ^7'h55, 1'b1);
        idle(1);
        n_checks++;
        if (got_q.size() != 1) $display("FAIL latency_count: got %0d expected 1", got_q.size()); else n_pass++;
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_checks += 2;
            if (g.lat != 153) $display("FAIL latency_cycles: got %0d expected 153", g.lat); else n_pass++;
            if (g.data !== 7'h55) $display("FAIL latency_data: got %h expected 55", g.data); else n_pass++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_good_frames();
        test_parity_error();
        test_random_frames();
        test_framing_break();
        test_glitch();
        test_reset_mid_frame();
        test_latency();
        n_checks++;
        if (multi != 0) $display("FAIL pronto_width: %0d extended pulses, required 0", multi); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_serial_7e1.md
# rx_serial_7e1

Asynchronous serial receiver for the 7E1 frame format (1 start, 7 data LSB-first, even parity, 1 stop). It sits behind the top-level `RX` pin, next to the sonar subsystem, and turns incoming command characters into a 7-bit word with a one-cycle `pronto` strobe and error flags. It is the receiving end of the same 7E1 link the design already uses for `saida_serial` output, so frames produced by the transmit path must decode cleanly here.

## Interface

- `BAUD_DIV`, default 434: clock cycles per bit (50 MHz / 115200).
- `HALF_DIV`, default `BAUD_DIV/2` (217): cycles from start-bit detection to the start-bit mid-sample.
- `clock` input, 1 bit: system clock, 50 MHz. One clock domain for the whole block.
- `reset` input, 1 bit: synchronous, active-high.
- `RX` input, 1 bit: serial line. Asynchronous to `clock`. Idle level is 1.
- `dado_recebido` output, 7 bits: last received data word, bit 0 is the first data bit on the line.
- `pronto` output, 1 bit: one-cycle pulse when a frame completes, whether the frame is good or bad.
- `erro_paridade` output, 1 bit: parity mismatch in the last frame.
- `erro_stop` output, 1 bit: stop bit sampled as 0 in the last frame (framing error).
- `ocupado` output, 1 bit: high whenever the FSM is not in `INICIAL`.

## Operation

- **Synchronizer.** `RX` passes through 2 flip-flops to give `rx_s`. All decisions use `rx_s`.
- **Counters.**
  - Bit-timer `tick_cnt`: 0..`BAUD_DIV`-1, cleared on every state entry.
  - Bit index `bit_cnt`: 0..6.
  - Shift register `sr[6:0]`: shifts right, new bit enters at `sr[6]`. After 7 shifts, the first bit received is in `sr[0]`.
- **FSM states and transitions.**
  - `INICIAL`: if `rx_s`=0, go to `START`.
  - `START`: wait `HALF_DIV` cycles, then sample `rx_s`. If 1, this is a false start: return to `INICIAL` with no `pronto` and no flag change. If 0, go to `DADOS`.
  - `DADOS`: every `BAUD_DIV` cycles, sample `rx_s` and shift it into `sr`. After the 7th sample, go to `PARIDADE`.
  - `PARIDADE`: after `BAUD_DIV` cycles, sample `p`. Compute `par_err = p ^ (^sr)`; even parity means `p` equals the XOR of the 7 data bits.
  - `STOP`: after `BAUD_DIV` cycles, sample `s`. Go to `FIM`.
  - `FIM`, one cycle only:
    - Load `dado_recebido` from `sr`, `erro_paridade` from `par_err`, and `erro_stop` from `~s`.
    - Assert `pronto`.
    - If `s`=1, go to `INICIAL`; otherwise go to `ESPERA`.
  - `ESPERA`: stay until `rx_s`=1, then go to `INICIAL`. This blocks a held-low line (break) from being taken as back-to-back starts.
- **Output holding.** Data and both flags change only in `FIM` and hold until the next `FIM` or reset. A frame with a parity or stop error still updates `dado_recebido`.
- **Reset.**
  - Values: FSM to `INICIAL`; all counters, `sr` and synchronizer flops to 0, except the synchronizer flops, which reset to 1 (idle). `dado_recebido`=0, `pronto`=0, `erro_paridade`=0, `erro_stop`=0, `ocupado`=0.
  - Reset mid-frame discards the partial frame with no `pronto`. After reset releases, reception restarts only on a new 1→0 level seen in `INICIAL`. If the line is low at release, it is taken as a start.

## Timing

- Let t0 be the cycle in which `INICIAL` sees `rx_s`=0. `RX` fell 2–3 cycles earlier.
- Sample points, in cycles after t0:
  - Start bit: t0+`HALF_DIV`.
  - Data bit k (k=0..6): t0+`HALF_DIV`+(k+1)·`BAUD_DIV`.
  - Parity bit: t0+`HALF_DIV`+8·`BAUD_DIV`.
  - Stop bit: t0+`HALF_DIV`+9·`BAUD_DIV`.
- `pronto` is high exactly one cycle, at t0+`HALF_DIV`+9·`BAUD_DIV`+1. With defaults this is t0+4124. Outputs are valid in that same cycle.
- Back-to-back frames: a start bit that begins right after the stop-bit sample is accepted. There is no minimum idle gap beyond the remaining half stop bit.
- Tolerated sender baud error: ±4% (mid-bit sampling over 10 bits).
- `ocupado` is high from t0+1 through the `FIM` cycle, and through `ESPERA` if that state is entered.

## Test plan

- **Good frames, back to back.** Reset, idle 100 µs. Send 0x2A (parity 1, stop 1), then 0x4C and 0x70 with a 10-bit gap between frames, at 8680 ns/bit. Expect `dado_recebido` = 0x2A, 0x4C, 0x70 in turn, three single-cycle `pronto` pulses, both flags 0.
- **Parity error.** Send 0x2A with the parity bit set to 0. Expect `pronto`, `dado_recebido`=0x2A, `erro_paridade`=1, `erro_stop`=0. Then send a good 0x4C: `erro_paridade` must return to 0.
- **Framing error and break.** Send 0x70 with a stop bit of 0, then hold `RX` low for 20 bit times. Expect exactly one `pronto` with `erro_stop`=1 and `ocupado`=1 throughout the break. After `RX` returns high, a good 0x2A decodes correctly.
- **Glitch rejection.** Pulse `RX` low for 50 cycles. Expect no `pronto`, `ocupado` to drop back to 0 after `HALF_DIV`+3 cycles, and outputs unchanged.
- **Reset mid-frame.** Assert `reset` for 1 cycle during data bit 3 of a 0x4C frame. Expect no `pronto` and all outputs 0. The next full 0x4C frame decodes correctly.
- **Latency check.** With `BAUD_DIV`=16 and `HALF_DIV`=8, send 0x55. Expect `pronto` exactly 153 cycles after t0, and `dado_recebido`=0x55.
